rle_decoder_64: RTL and testbench

- Decodes one RLE-packed 8x8 coefficient block back into 64 signed coefficients in scan order, emitted one per cycle.
- The input is the 896-bit packed word produced by the RLE encoder: 64 slots of 14 bits, MSB-first, terminated by the EOB marker 14'h3FFF, zero-padded after EOB.
- Sits between the entropy-decode path and the inverse zig-zag/dequantiser in the decode chain.
- Valid/ready handshake on the block input and on the coefficient output.

---
 rtl/rle_decoder_64.sv | 152 +++++++++++++++
 tb/tb_rle_decoder_64.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rle_decoder_64.sv
// RLE block decoder: expands one packed 64-slot run/level word into 64 signed
// coefficients in scan order, one beat per cycle, with valid/ready on both sides.
module rle_decoder_64 #(
   parameter int N_COEF  = 64,
   parameter int RUN_W   = 4,
   parameter int LEVEL_W = 10,
   parameter int ENTRY_W = 14,
   parameter logic [13:0] EOB = 14'h3FFF
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_COEF*ENTRY_W-1:0]   in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [LEVEL_W-1:0]          out_coef,
   output logic [5:0]                  out_index,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_last,
   output logic                        out_err
);

   localparam int BLK_W = N_COEF * ENTRY_W;

   typedef enum logic [2:0] {IDLE, FETCH, ZERO, LEVEL, FILL} state_t;

   state_t               state_reg, state_next;
   logic [BLK_W-1:0]     blk_reg, blk_next;
   logic [6:0]           cnt_reg, cnt_next;
   logic [RUN_W-1:0]     run_reg, run_next;
   logic [LEVEL_W-1:0]   level_reg, level_next;
   logic                 out_valid_reg, out_valid_next;
   logic [LEVEL_W-1:0]   out_coef_reg, out_coef_next;
   logic [5:0]           out_index_reg, out_index_next;
   logic                 out_last_reg, out_last_next;
   logic                 out_err_reg, out_err_next;

   logic [ENTRY_W-1:0]   top_slot;
   logic                 adv;
   logic                 done;
   logic                 fire_last;
   logic                 emit;
   logic [LEVEL_W-1:0]   emit_val;

   assign top_slot  = blk_reg[BLK_W-1 -: ENTRY_W];
   assign adv       = !out_valid_reg || out_ready;
   assign done      = cnt_reg[6];
   assign fire_last = out_valid_reg && out_ready && out_last_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg     <= IDLE;
         blk_reg       <= '0;
         cnt_reg       <= '0;
         run_reg       <= '0;
         level_reg     <= '0;
         out_valid_reg <= 1'b0;
         out_coef_reg  <= '0;
         out_index_reg <= '0;
         out_last_reg  <= 1'b0;
         out_err_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         blk_reg       <= blk_next;
         cnt_reg       <= cnt_next;
         run_reg       <= run_next;
         level_reg     <= level_next;
         out_valid_reg <= out_valid_next;
         out_coef_reg  <= out_coef_next;
         out_index_reg <= out_index_next;
         out_last_reg  <= out_last_next;
         out_err_reg   <= out_err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      blk_next       = blk_reg;
      cnt_next       = cnt_reg;
      run_next       = run_reg;
      level_next     = level_reg;
      out_valid_next = out_valid_reg;
      out_coef_next  = out_coef_reg;
      out_index_next = out_index_reg;
      out_last_next  = out_last_reg;
      out_err_next   = out_err_reg;
      emit           = 1'b0;
      emit_val       = '0;
      in_ready       = (state_reg == IDLE);

      if (state_reg == IDLE) begin
         if (in_valid) begin
            blk_next   = in_data;
            cnt_next   = '0;
            run_next   = '0;
            level_next = '0;
            state_next = FETCH;
         end
      end else if (fire_last) begin
         // The index-63 handshake ends the block whatever is still pending.
         state_next     = IDLE;
         out_valid_next = 1'b0;
         out_last_next  = 1'b0;
         out_err_next   = 1'b0;
      end else if (adv && !done) begin
         out_valid_next = 1'b0;
         case (state_reg)
            FETCH: begin
               if (top_slot == EOB) begin
                  state_next = FILL;
               end else begin
                  run_next   = top_slot[ENTRY_W-1 -: RUN_W];
                  level_next = top_slot[LEVEL_W-1:0];
                  state_next = (top_slot[ENTRY_W-1 -: RUN_W] != '0) ? ZERO : LEVEL;
               end
            end
            ZERO: begin
               emit     = 1'b1;
               run_next = run_reg - 1'b1;
               if (run_reg == 4'd1) state_next = LEVEL;
            end
            LEVEL: begin
               emit       = 1'b1;
               emit_val   = level_reg;
               blk_next   = {blk_reg[BLK_W-ENTRY_W-1:0], {ENTRY_W{1'b0}}};
               state_next = FETCH;
            end
            FILL: begin
               emit = 1'b1;
            end
            default: state_next = IDLE;
         endcase

         if (emit) begin
            out_valid_next = 1'b1;
            out_coef_next  = emit_val;
            out_index_next = cnt_reg[5:0];
            out_last_next  = (cnt_reg == 7'd63);
            // A zero beat at index 63 always leaves at least the level unsent.
            out_err_next   = (cnt_reg == 7'd63) && (state_reg == ZERO);
            cnt_next       = cnt_reg + 7'd1;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign out_coef  = out_coef_reg;
   assign out_index = out_index_reg;
   assign out_last  = out_last_reg;
   assign out_err   = out_err_reg;

endmodule

// File: tb/tb_rle_decoder_64.sv
// Bench for rle_decoder_64: directed and random blocks checked beat-by-beat
// against a slot-list expansion model.
module tb_rle_decoder_64;

   logic         clk = 1'b0;
   logic         reset;
   logic [895:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [9:0]   out_coef;
   logic [5:0]   out_index;
   logic         out_valid;
   logic         out_ready;
   logic         out_last;
   logic         out_err;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   logic [13:0] slots [64];
   logic [9:0]  exp_coef [64];
   logic        exp_err;

   localparam logic [13:0] EOB = 14'h3FFF;

   always #5 clk = ~clk;

   rle_decoder_64 dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_coef  (out_coef),
      .out_index (out_index),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .out_err   (out_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Expand the slot list: each slot is `run` zeros then its level; anything
   // that does not fit in 64 coefficients marks the block truncated.
   task automatic model();
      int n = 0;
      exp_err = 1'b0;
      for (int i = 0; i < 64; i++) exp_coef[i] = '0;
      for (int k = 0; k < 64; k++) begin
         if (n == 64 || slots[k] == EOB) break;
         for (int j = 0; j < int'(slots[k][13:10]); j++) begin
            if (n < 64) begin exp_coef[n] = '0; n++; end
            else exp_err = 1'b1;
         end
         if (n < 64) begin exp_coef[n] = slots[k][9:0]; n++; end
         else exp_err = 1'b1;
      end
   endtask

   task automatic clear_slots();
      for (int k = 0; k < 64; k++) slots[k] = '0;
   endtask

   // mode 0: out_ready always 1; 1: random; 2: 3-cycle stall on index 2
   task automatic run_block(input string name, input int mode);
      logic [895:0] d;
      int t = 0, cyc = 1, n = 0, first = -1, stall = 0;
      logic held = 1'b0;
      logic [9:0] hcoef;
      logic [5:0] hidx;
      logic r;
      model();
      for (int k = 0; k < 64; k++) d[895-14*k -: 14] = slots[k];
      @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      while (!in_ready && t < 100) begin @(negedge clk); t++; end
      check({name, " accept"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      check({name, " busy"}, in_ready, 0);
      while (n < 64 && cyc < 3000) begin
         case (mode)
            0: r = 1'b1;
            1: r = ($urandom_range(0, 3) != 0);
            default: begin
               if (out_valid && out_index == 6'd2 && stall < 3) begin r = 1'b0; stall++; end
               else r = 1'b1;
            end
         endcase
         out_ready = r;
         if (held) begin
            check({name, " hold valid"}, out_valid, 1);
            check({name, " hold coef"}, out_coef, hcoef);
            check({name, " hold index"}, out_index, hidx);
         end
         if (out_valid && first < 0) first = cyc;
         if (out_valid && out_ready) begin
            check($sformatf("%s coef[%0d]", name, n), out_coef, exp_coef[n]);
            check($sformatf("%s index[%0d]", name, n), out_index, n);
            check($sformatf("%s last[%0d]", name, n), out_last, (n == 63));
            check($sformatf("%s err[%0d]", name, n), out_err, (n == 63) ? exp_err : 1'b0);
            n++;
            held = 1'b0;
         end else if (out_valid) begin
            held  = 1'b1;
            hcoef = out_coef;
            hidx  = out_index;
         end else begin
            held = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      check({name, " beats"}, n, 64);
      check({name, " latency"}, first, 3);
      check({name, " idle ready"}, in_ready, 1);
      check({name, " idle valid"}, out_valid, 0);
      $display("block %s: mode=%0d beats=%0d cycles=%0d err=%0d", name, mode, n, cyc, exp_err);
      out_ready = 1'b1;
   endtask

   task automatic gen_random();
      int ns = ($urandom_range(0, 7) == 0) ? 64 : $urandom_range(0, 40);
      for (int k = 0; k < 64; k++) begin
         if (k < ns) begin
            slots[k][13:10] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                         : 4'($urandom_range(0, 2));
            slots[k][9:0]   = 10'($urandom);
            if (slots[k] == EOB) slots[k] = 14'h3FFE;
         end else if (k == ns) begin
            slots[k] = EOB;
         end else begin
            slots[k] = 14'($urandom);
         end
      end
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst in_ready", in_ready, 1);
      check("rst out_valid", out_valid, 0);
      check("rst out_coef", out_coef, 0);
      check("rst out_index", out_index, 0);
      check("rst out_last", out_last, 0);
      check("rst out_err", out_err, 0);
      reset = 1'b1;

      clear_slots(); slots[0] = {4'd0, 10'd5}; slots[1] = EOB;
      run_block("single", 0);

      clear_slots(); slots[0] = {4'd2, 10'h3FE}; slots[1] = {4'd0, 10'd7}; slots[2] = EOB;
      run_block("run2", 0);

      clear_slots(); slots[0] = EOB;
      run_block("eob_only", 0);

      clear_slots(); slots[0] = {4'd2, 10'h3FE}; slots[1] = {4'd0, 10'd7}; slots[2] = EOB;
      run_block("stall", 2);

      for (int k = 0; k < 63; k++) slots[k] = {4'd0, 10'd1};
      slots[63] = {4'd5, 10'd9};
      run_block("overflow", 0);

      // Reset in the middle of a block, then a fresh block must start at index 0.
      for (int k = 0; k < 64; k++) slots[k] = {4'd0, 10'(k + 1)};
      begin
         logic [895:0] d;
         int t = 0;
         for (int k = 0; k < 64; k++) d[895-14*k -: 14] = slots[k];
         @(negedge clk);
         in_data  = d;
         in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         while (!(out_valid && out_index == 6'd10) && t < 500) begin @(negedge clk); t++; end
         check("midrst reach idx10", out_index, 10);
         reset = 1'b0;
         @(negedge clk);
         check("midrst out_valid", out_valid, 0);
         check("midrst in_ready", in_ready, 1);
         reset = 1'b1;
         $display("block midrst: reset at index 10");
      end
      clear_slots(); slots[0] = {4'd0, 10'd3}; slots[1] = EOB;
      run_block("after_rst", 0);

      for (int b = 0; b < 25; b++) begin
         gen_random();
         run_block($sformatf("rand%0d", b), 1);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
